// File: rtl/coverfloat_pkg.sv
// Coverfloat transaction record shared by the monitor packer,
// the arbiter interface and the arbiter itself.
package coverfloat_pkg;

  typedef struct packed {
    logic [31:0]  op;
    logic [31:0]  rm;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    logic [7:0]   aFmt;
    logic [7:0]   bFmt;
    logic [7:0]   cFmt;
    logic [127:0] result;
    logic [7:0]   resultFmt;
    logic [31:0]  exceptionBits;
  } coverfloat_txn_t;

  localparam int COVERFLOAT_TXN_W = $bits(coverfloat_txn_t);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coverfloat_txn_arbiter_if.sv
// Requester side (NUM_REQ valid/ready lanes) and sampler side
// (single valid/ready channel) of the coverfloat arbiter.
interface coverfloat_txn_arbiter_if
  import coverfloat_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 32
);

  localparam int SRC_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  coverfloat_txn_t [NUM_REQ-1:0] req_txn;

  logic                          out_valid;
  logic                          out_ready;
  coverfloat_txn_t               out_txn;
  logic [SRC_W-1:0]              out_src;
  logic [SEQ_W-1:0]              out_seq;

  modport master (
    input  req_valid,
    input  req_txn,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_txn,
    output out_src,
    output out_seq
  );

  modport slave (
    output req_valid,
    output req_txn,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_txn,
    input  out_src,
    input  out_seq
  );

endinterface

// File: rtl/coverfloat_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping to 0. Pointer state is kept by the caller.
module coverfloat_rr_arbiter
  import coverfloat_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  localparam int        CW = IW + 1;
  localparam logic [IW:0] N = CW'(NUM_REQ);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= N) cand = cand - N;
      if (!any && req[cand[IW-1:0]]) begin
        any = 1'b1;
        idx = cand[IW-1:0];
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/coverfloat_txn_arbiter.sv
// Round-robin merge of NUM_REQ coverfloat monitors into one
// registered, sequence-tagged sampler channel.
module coverfloat_txn_arbiter
  import coverfloat_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEQ_W   = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  coverfloat_txn_arbiter_if.master  bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_d;
  logic [SEQ_W-1:0]     seq_q;
  logic [SEQ_W-1:0]     seq_out_q;
  logic [IW-1:0]        src_q;
  coverfloat_txn_t      txn_q;

  logic [NUM_REQ-1:0]   win_grant;
  logic [IW-1:0]        win_idx;
  logic                 win_any;
  logic                 slot_free;
  logic                 fire;

  coverfloat_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // rst_n gate keeps every requester stalled while reset is held
  assign slot_free = (state_q == EMPTY) || bus.out_ready;
  assign fire      = rst_n && slot_free && win_any;

  assign bus.req_ready = fire ? win_grant : '0;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_txn   = txn_q;
  assign bus.out_src   = src_q;
  assign bus.out_seq   = seq_out_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL:  if (bus.out_ready && !fire) state_d = EMPTY;
    endcase
    if (fire) ptr_d = (win_idx == LAST) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      seq_q     <= '0;
      seq_out_q <= '0;
      src_q     <= '0;
      txn_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (fire) begin
        txn_q     <= bus.req_txn[win_idx];
        src_q     <= win_idx;
        seq_out_q <= seq_q;
        seq_q     <= seq_q + 1'b1;
      end
    end
  end

endmodule
